// File: rtl/pll_clock_manager_pkg.sv
// Shared definitions for the post-PLL clock/reset manager: FSM encodings,
// loss counter width and a constant-foldable clog2 helper.
package pll_clock_manager_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam int LOSS_CNT_W = 8;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pll_clock_manager_ce_divider.sv
// One clock-enable channel: counts 0..div-1 while running and strobes on the
// last count. New divisors wait in a pending register until the next wrap.
module ce_divider #(
  parameter int               DIV_W   = 16,
  parameter logic [DIV_W-1:0] DIV_RST = 16'd2
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             run,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_val,
  output logic             ce
);

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] pend_r;
  logic             pend_vld_r;
  logic             run_r;
  logic             ce_r;

  logic [DIV_W-1:0] last_s;
  logic             wrap_s;
  logic             apply_s;
  logic [DIV_W-1:0] div_next_s;
  logic [DIV_W-1:0] cnt_next_s;
  logic [DIV_W-1:0] last_next_s;
  logic             ce_next_s;

  // Look one cycle ahead so the strobe can come straight out of a flop.
  always_comb begin
    last_s      = {DIV_W{1'b0}};
    last_next_s = {DIV_W{1'b0}};
    if (div_r > DIV_W'(1)) begin
      last_s = div_r - DIV_W'(1);
    end else begin
      last_s = {DIV_W{1'b0}};
    end
    wrap_s     = run_r && (cnt_r == last_s);
    apply_s    = pend_vld_r && (!run_r || wrap_s);
    div_next_s = apply_s ? pend_r : div_r;
    if (!run || !run_r || wrap_s) begin
      cnt_next_s = {DIV_W{1'b0}};
    end else begin
      cnt_next_s = cnt_r + DIV_W'(1);
    end
    if (div_next_s > DIV_W'(1)) begin
      last_next_s = div_next_s - DIV_W'(1);
    end else begin
      last_next_s = {DIV_W{1'b0}};
    end
    ce_next_s = run && (cnt_next_s == last_next_s);
  end

  // Counter, active divisor, pending divisor and strobe registers.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r      <= {DIV_W{1'b0}};
      div_r      <= DIV_RST;
      pend_r     <= {DIV_W{1'b0}};
      pend_vld_r <= 1'b0;
      run_r      <= 1'b0;
      ce_r       <= 1'b0;
    end else begin
      cnt_r <= cnt_next_s;
      div_r <= div_next_s;
      run_r <= run;
      ce_r  <= ce_next_s;
      // A write landing on the wrap cycle is kept for the following wrap.
      if (wr_en) begin
        pend_r     <= wr_val;
        pend_vld_r <= 1'b1;
      end else if (apply_s) begin
        pend_vld_r <= 1'b0;
      end else begin
        pend_vld_r <= pend_vld_r;
      end
    end
  end

  assign ce = ce_r;

endmodule

// File: rtl/pll_clock_manager.sv
// Post-PLL clock/reset manager: qualifies PLL lock, sequences the downstream
// reset and drives the per-channel clock-enable dividers.
module pll_clock_manager
  import pll_clock_manager_pkg::*;
#(
  parameter int                      NUM_CH            = 4,
  parameter int                      DIV_W             = 16,
  parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT          = {NUM_CH{16'd2}},
  parameter int                      LOCK_HOLD_CYCLES  = 1024,
  parameter int                      RESET_HOLD_CYCLES = 16,
  localparam int                     CH_W              = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
  input  logic                  clock_in,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  div_wr_en,
  input  logic [CH_W-1:0]       div_wr_ch,
  input  logic [DIV_W-1:0]      div_wr_val,
  output logic                  rst_out_n,
  output logic [NUM_CH-1:0]     ce_out,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_count,
  output logic [1:0]            state
);

  localparam int HOLD_MAX = (LOCK_HOLD_CYCLES > RESET_HOLD_CYCLES) ? LOCK_HOLD_CYCLES
                                                                    : RESET_HOLD_CYCLES;
  localparam int HOLD_W = clog2(HOLD_MAX) + 1;
  localparam logic [HOLD_W-1:0] LOCK_LAST  = HOLD_W'(LOCK_HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] RESET_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  logic                  lock_meta_r;
  logic                  lock_sync_r;
  state_t                state_r;
  state_t                state_next_s;
  logic [HOLD_W-1:0]     hold_cnt_r;
  logic [HOLD_W-1:0]     hold_next_s;
  logic [LOSS_CNT_W-1:0] loss_cnt_r;
  logic [LOSS_CNT_W-1:0] loss_next_s;
  logic                  run_r;
  logic                  run_next_s;

  // Two-flop synchroniser for the asynchronous PLL lock flag.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
    end else begin
      lock_meta_r <= pll_locked;
      lock_sync_r <= lock_meta_r;
    end
  end

  // Lock qualification sequence, hold counting and lock-loss accounting.
  always_comb begin
    state_next_s = state_r;
    hold_next_s  = hold_cnt_r;
    loss_next_s  = loss_cnt_r;
    case (state_r)
      ST_WAIT_LOCK: begin
        hold_next_s = {HOLD_W{1'b0}};
        if (lock_sync_r) begin
          state_next_s = ST_STABLE;
        end else begin
          state_next_s = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        if (!lock_sync_r) begin
          state_next_s = ST_WAIT_LOCK;
          hold_next_s  = {HOLD_W{1'b0}};
        end else if (hold_cnt_r == LOCK_LAST) begin
          state_next_s = ST_RELEASE;
          hold_next_s  = {HOLD_W{1'b0}};
        end else begin
          hold_next_s = hold_cnt_r + HOLD_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!lock_sync_r) begin
          state_next_s = ST_WAIT_LOCK;
          hold_next_s  = {HOLD_W{1'b0}};
        end else if (hold_cnt_r == RESET_LAST) begin
          state_next_s = ST_RUN;
          hold_next_s  = {HOLD_W{1'b0}};
        end else begin
          hold_next_s = hold_cnt_r + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        hold_next_s = {HOLD_W{1'b0}};
        if (!lock_sync_r) begin
          state_next_s = ST_WAIT_LOCK;
          if (loss_cnt_r != {LOSS_CNT_W{1'b1}}) begin
            loss_next_s = loss_cnt_r + LOSS_CNT_W'(1);
          end else begin
            loss_next_s = loss_cnt_r;
          end
        end else begin
          state_next_s = ST_RUN;
        end
      end
      default: begin
        state_next_s = ST_WAIT_LOCK;
        hold_next_s  = {HOLD_W{1'b0}};
      end
    endcase
    run_next_s = (state_next_s == ST_RUN);
  end

  // State, counters and the RUN flag that drives rst_out_n/ready.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_WAIT_LOCK;
      hold_cnt_r <= {HOLD_W{1'b0}};
      loss_cnt_r <= {LOSS_CNT_W{1'b0}};
      run_r      <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      hold_cnt_r <= hold_next_s;
      loss_cnt_r <= loss_next_s;
      run_r      <= run_next_s;
    end
  end

  assign rst_out_n       = run_r;
  assign ready           = run_r;
  assign lock_loss_count = loss_cnt_r;
  assign state           = state_r;

  // Dividers see next-cycle RUN so all channels restart phase-aligned.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_en_s;
    assign wr_en_s = div_wr_en && (div_wr_ch == CH_W'(i));
    ce_divider #(
      .DIV_W  (DIV_W),
      .DIV_RST(DIV_INIT[i*DIV_W +: DIV_W])
    ) u_div (
      .clock_in(clock_in),
      .reset_n (reset_n),
      .run     (run_next_s),
      .wr_en   (wr_en_s),
      .wr_val  (div_wr_val),
      .ce      (ce_out[i])
    );
  end

endmodule

// File: tb/tb_pll_clock_manager.sv
// Directed bench for pll_clock_manager: lock qualification timing, glitch
// restart, divider patterns, pending divisor writes, loss saturation, reset.
module tb_pll_clock_manager;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 16;
  localparam int LH     = 8;
  localparam int RH     = 4;

  logic              clock_in;
  logic              reset_n;
  logic              pll_locked;
  logic              div_wr_en;
  logic [1:0]        div_wr_ch;
  logic [DIV_W-1:0]  div_wr_val;
  logic              rst_out_n;
  logic [NUM_CH-1:0] ce_out;
  logic              ready;
  logic [7:0]        lock_loss_count;
  logic [1:0]        state;

  int checks = 0;
  int errors = 0;
  logic [NUM_CH-1:0] ce_q[$];
  logic [NUM_CH-1:0] ce_exp;
  int loss_model;

  pll_clock_manager #(
    .NUM_CH           (NUM_CH),
    .DIV_W            (DIV_W),
    .DIV_INIT         ({16'd1, 16'd4, 16'd3, 16'd0}),
    .LOCK_HOLD_CYCLES (LH),
    .RESET_HOLD_CYCLES(RH)
  ) dut (
    .clock_in       (clock_in),
    .reset_n        (reset_n),
    .pll_locked     (pll_locked),
    .div_wr_en      (div_wr_en),
    .div_wr_ch      (div_wr_ch),
    .div_wr_val     (div_wr_val),
    .rst_out_n      (rst_out_n),
    .ce_out         (ce_out),
    .ready          (ready),
    .lock_loss_count(lock_loss_count),
    .state          (state)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // State expected k cycles after pll_locked was raised (2 sync + hold counts).
  function automatic logic [1:0] exp_state(input int k);
    if (k <= 2) return 2'd0;
    else if (k <= 2 + LH) return 2'd1;
    else if (k <= 2 + LH + RH) return 2'd2;
    else return 2'd3;
  endfunction

  // ch0/ch3 every cycle, ch1 every 3rd; ch2 schedule depends on rewrites.
  function automatic logic [NUM_CH-1:0] ce_model(input int n, input bit rewritten);
    logic [NUM_CH-1:0] e;
    e[0] = 1'b1;
    e[3] = 1'b1;
    e[1] = (n % 3 == 0);
    if (!rewritten || n <= 16) e[2] = (n % 4 == 0);
    else if (n <= 36) e[2] = ((n - 16) % 10 == 0);
    else e[2] = ((n - 36) % 5 == 0);
    return e;
  endfunction

  // Walk cycles 1..14 after the lock raise; checks begin at cycle first_k.
  task automatic qual(input int first_k);
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k >= first_k) begin
        check("qual_state", 32'(state), 32'(exp_state(k)));
        check("qual_ready", 32'(ready), 32'(1'b0));
        check("qual_rst", 32'(rst_out_n), 32'(1'b0));
        check("qual_ce", 32'(ce_out), 32'(4'd0));
      end
    end
  endtask

  task automatic write_div(input logic [1:0] ch, input logic [DIV_W-1:0] val);
    div_wr_en  = 1'b1;
    div_wr_ch  = ch;
    div_wr_val = val;
  endtask

  initial begin
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    div_wr_en  = 1'b0;
    div_wr_ch  = 2'd0;
    div_wr_val = 16'd0;
    repeat (3) tick();
    check("rst_rst_out_n", 32'(rst_out_n), 32'(1'b0));
    check("rst_ready", 32'(ready), 32'(1'b0));
    check("rst_ce", 32'(ce_out), 32'(4'd0));
    check("rst_loss", 32'(lock_loss_count), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    reset_n = 1'b1;
    repeat (3) tick();
    check("idle_state", 32'(state), 32'd0);

    // Lock with a one-cycle glitch in STABLE, then full requalification.
    pll_locked = 1'b1;
    repeat (5) tick();
    check("glitch_pre_state", 32'(state), 32'd1);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    qual(2);
    check("glitch_loss", 32'(lock_loss_count), 32'd0);

    // RUN: divider pattern, then ch2 rewrites (6 then 10, then 5 on a wrap).
    for (int n = 1; n <= 47; n++) begin
      ce_q.push_back(ce_model(n, 1'b1));
      tick();
      check("run_ready", 32'(ready), 32'(1'b1));
      check("run_rst", 32'(rst_out_n), 32'(1'b1));
      ce_exp = ce_q.pop_front();
      check($sformatf("ce_n%0d", n), 32'(ce_out), 32'(ce_exp));
      div_wr_en = 1'b0;
      if (n == 13) write_div(2'd2, 16'd6);
      if (n == 14) write_div(2'd2, 16'd10);
      if (n == 26) write_div(2'd2, 16'd5);
    end
    div_wr_en = 1'b0;

    // Repeated lock loss from RUN; counter saturates at 255.
    loss_model = 0;
    for (int i = 1; i <= 300; i++) begin
      if (i > 1) begin
        pll_locked = 1'b1;
        repeat (15) tick();
        check("loss_ready", 32'(ready), 32'(1'b1));
      end
      pll_locked = 1'b0;
      repeat (2) tick();
      check("loss_rst_late", 32'(rst_out_n), 32'(1'b1));
      tick();
      check("loss_rst", 32'(rst_out_n), 32'(1'b0));
      check("loss_ce", 32'(ce_out), 32'(4'd0));
      if (loss_model < 255) loss_model++;
      check("loss_cnt", 32'(lock_loss_count), 32'(loss_model));
    end

    // Async reset mid-RUN, then requalification with DIV_INIT restored.
    pll_locked = 1'b1;
    qual(1);
    repeat (5) tick();
    check("pre_reset_ready", 32'(ready), 32'(1'b1));
    reset_n = 1'b0;
    #1;
    check("async_rst_out_n", 32'(rst_out_n), 32'(1'b0));
    check("async_ready", 32'(ready), 32'(1'b0));
    check("async_ce", 32'(ce_out), 32'(4'd0));
    check("async_state", 32'(state), 32'd0);
    check("async_loss", 32'(lock_loss_count), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    qual(1);
    for (int n = 1; n <= 8; n++) begin
      ce_q.push_back(ce_model(n, 1'b0));
      tick();
      check("post_ready", 32'(ready), 32'(1'b1));
      ce_exp = ce_q.pop_front();
      check($sformatf("post_ce_n%0d", n), 32'(ce_out), 32'(ce_exp));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
